// File: rtl/alu_result_display_pkg.sv
// alu_result_display_pkg: shared constants, types and helpers for the ALU
// result display block.
//   ST_*        FSM state encodings (IDLE -> CONVERT -> LOAD)
//   SEG_*       active-low {g,f,e,d,c,b,a} segment codes
//   disp_t      double-buffered display contents (sign, BCD digits, flags)
//   seg_lookup  BCD digit -> segment code; 10-15 decode to blank
//   dd_adjust   double-dabble add-3 step applied to every BCD nibble
package alu_result_display_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_LOAD    = 2'd2;

  localparam int NUM_DIGITS = 4;
  localparam int NUM_BCD    = 3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef struct packed {
    logic                    sign;
    logic [NUM_BCD-1:0][3:0] bcd;   // [2]=hundreds, [1]=tens, [0]=ones
    logic                    ovf;
    logic                    carry;
    logic                    zero;
  } disp_t;

  function automatic logic [6:0] seg_lookup(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [4*NUM_BCD-1:0] dd_adjust(input logic [4*NUM_BCD-1:0] b);
    logic [4*NUM_BCD-1:0] r;
    r = b;
    for (int i = 0; i < NUM_BCD; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

endpackage

// File: rtl/alu_result_display_seg7_decoder.sv
// seg7_decoder: combinational BCD digit -> active-low 7-segment code.
//   bcd    in   4  digit value (10-15 decode to blank)
//   blank  in   1  force all segments off
//   seg    out  7  {g,f,e,d,c,b,a}, active-low
module seg7_decoder
  import alu_result_display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb seg = blank ? SEG_BLANK : seg_lookup(bcd);

endmodule

// File: rtl/alu_result_display.sv
// alu_result_display: captures a signed ALU result plus flags over valid/ready,
// converts |result| to three BCD digits with a sequential double-dabble, and
// drives a 4-digit multiplexed active-low 7-segment display and flag LEDs.
//   clk, reset     rising-edge clock, synchronous active-high reset
//   result         signed ALU result, WIDTH+2 bits
//   zero/carry_out/overflow   ALU flags, captured with result
//   result_valid   producer holds result+flags until accepted
//   result_ready   high only while idle
//   seg/an/dp      registered display pins (active-low), an[3] leftmost
//   led_flags      {overflow, carry_out, zero} of the displayed result
module alu_result_display
  import alu_result_display_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH+1:0] result,
  input  logic             zero,
  input  logic             carry_out,
  input  logic             overflow,
  input  logic             result_valid,
  output logic             result_ready,
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic             dp,
  output logic [2:0]       led_flags
);

  localparam int RW = WIDTH + 2;
  localparam int CW = $clog2(RW + 1);
  localparam int PW = $clog2(REFRESH_DIV);

  logic [1:0]           state;
  logic [RW-1:0]        mag;
  logic [4*NUM_BCD-1:0] bcd_acc;
  logic [CW-1:0]        bit_cnt;
  logic                 cap_sign;
  logic [2:0]           cap_flags;  // {ovf, carry, zero}
  disp_t                disp;

  assign result_ready = (state == ST_IDLE);
  assign led_flags    = {disp.ovf, disp.carry, disp.zero};

  // Conversion FSM. The display buffer is only written in LOAD, so the scan
  // never sees a half-built BCD value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mag       <= '0;
      bcd_acc   <= '0;
      bit_cnt   <= '0;
      cap_sign  <= 1'b0;
      cap_flags <= '0;
      disp      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (result_valid) begin
            cap_sign  <= result[RW-1];
            cap_flags <= {overflow, carry_out, zero};
            // Two's-complement magnitude; the most negative value maps to
            // 2^(RW-1), which still fits unsigned in RW bits.
            mag       <= result[RW-1] ? (~result + 1'b1) : result;
            bcd_acc   <= '0;
            bit_cnt   <= CW'(RW);
            state     <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          {bcd_acc, mag} <= {dd_adjust(bcd_acc), mag} << 1;
          bit_cnt        <= bit_cnt - 1'b1;
          if (bit_cnt == CW'(1)) state <= ST_LOAD;
        end
        ST_LOAD: begin
          disp.sign  <= cap_sign;
          disp.bcd   <= bcd_acc;
          disp.ovf   <= cap_flags[2];
          disp.carry <= cap_flags[1];
          disp.zero  <= cap_flags[0];
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Digit scan, free-running regardless of the FSM.
  logic [PW-1:0] prescale;
  logic [1:0]    scan_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= '0;
      scan_idx <= '0;
    end else if (prescale == PW'(REFRESH_DIV - 1)) begin
      prescale <= '0;
      scan_idx <= scan_idx + 1'b1;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  // Leading-zero blanking: a digit blanks when it and every higher digit is
  // zero; the ones digit always shows.
  logic [NUM_BCD-1:0]      dig_blank;
  logic [NUM_BCD-1:0][6:0] dig_seg;

  always_comb begin
    logic lead_zero;
    dig_blank = '0;
    lead_zero = 1'b1;
    for (int i = NUM_BCD - 1; i >= 1; i--) begin
      lead_zero    = lead_zero & (disp.bcd[i] == 4'd0);
      dig_blank[i] = lead_zero;
    end
  end

  for (genvar g = 0; g < NUM_BCD; g++) begin : g_dec
    seg7_decoder u_dec (
      .bcd   (disp.bcd[g]),
      .blank (dig_blank[g]),
      .seg   (dig_seg[g])
    );
  end

  logic [6:0] seg_next;

  always_comb begin
    seg_next = SEG_BLANK;
    case (scan_idx)
      2'd0: seg_next = dig_seg[0];
      2'd1: seg_next = dig_seg[1];
      2'd2: seg_next = dig_seg[2];
      2'd3: seg_next = disp.sign ? SEG_MINUS : SEG_BLANK;
      default: seg_next = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
      dp  <= 1'b1;
    end else begin
      seg <= seg_next;
      an  <= ~(4'b0001 << scan_idx);
      dp  <= ~((scan_idx == 2'd0) & disp.ovf);
    end
  end

endmodule

// File: tb/tb_alu_result_display.sv
module tb_alu_result_display;

  localparam int WIDTH = 4;
  localparam int RDIV  = 4;
  localparam int RW    = WIDTH + 2;
  localparam int LAT   = WIDTH + 3;   // accept edge to display-load edge

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [RW-1:0] result = '0;
  logic          zero = 1'b0, carry_out = 1'b0, overflow = 1'b0;
  logic          result_valid = 1'b0;
  logic          result_ready;
  logic [6:0]    seg;
  logic [3:0]    an;
  logic          dp;
  logic [2:0]    led_flags;

  alu_result_display #(.WIDTH(WIDTH), .REFRESH_DIV(RDIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .result       (result),
    .zero         (zero),
    .carry_out    (carry_out),
    .overflow     (overflow),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .seg          (seg),
    .an           (an),
    .dp           (dp),
    .led_flags    (led_flags)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [6:0] dcode(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_digit(input int v, input int idx);
    int a, h, t, o;
    a = (v < 0) ? -v : v;
    h = a / 100;
    t = (a / 10) % 10;
    o = a % 10;
    case (idx)
      3: return (v < 0) ? 7'b0111111 : 7'h7F;
      2: return (h == 0) ? 7'h7F : dcode(h);
      1: return (h == 0 && t == 0) ? 7'h7F : dcode(t);
      default: return dcode(o);
    endcase
  endfunction

  bit         m_on = 1'b0;
  int         m_cyc, m_busy, m_pend_val, m_val, m_idx;
  logic [2:0] m_pend_f, m_flags;
  logic [6:0] e_seg;
  logic [3:0] e_an;
  logic       e_dp, e_rdy;
  logic [2:0] e_led;

  always @(posedge clk) begin
    if (reset) begin
      m_on = 1'b1; m_cyc = 0; m_busy = 0; m_val = 0; m_flags = '0;
      e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1; e_led = '0; e_rdy = 1'b1;
    end else if (m_on) begin
      m_cyc++;
      // Pins show the digit selected during the previous cycle.
      m_idx = ((m_cyc - 1) / RDIV) % 4;
      e_seg = exp_digit(m_val, m_idx);
      e_an  = ~(4'b0001 << m_idx);
      e_dp  = !(m_idx == 0 && m_flags[2]);
      if (m_busy == 0) begin
        if (result_valid) begin
          m_pend_val = int'($signed(result));
          m_pend_f   = {overflow, carry_out, zero};
          m_busy     = LAT;
        end
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          m_val   = m_pend_val;
          m_flags = m_pend_f;
        end
      end
      e_led = m_flags;
      e_rdy = (m_busy == 0);
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("seg", seg, e_seg);
      chk("an", 7'(an), 7'(e_an));
      chk("dp", 7'(dp), 7'(e_dp));
      chk("led_flags", 7'(led_flags), 7'(e_led));
      chk("result_ready", 7'(result_ready), 7'(e_rdy));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_an(input logic [3:0] tgt);
    bit hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (an === tgt) begin hit = 1'b1; break; end
    end
    if (!hit) chk("wait_an_timeout", 7'(an), 7'(tgt));
  endtask

  task automatic send(input logic [RW-1:0] v, input logic z, input logic c, input logic o);
    bit hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_ready) begin hit = 1'b1; break; end
    end
    if (!hit) chk("send_ready_timeout", 7'(result_ready), 7'd1);
    result = v; zero = z; carry_out = c; overflow = o; result_valid = 1'b1;
    @(posedge clk); #1;
    result_valid = 1'b0;
  endtask

  // Returns the number of negedges with ready low, then one extra cycle so
  // the output registers reflect the new display contents.
  task automatic wait_idle(output int lows);
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_ready) break;
      lows++;
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    int lows;
    // 1: reset then idle scan of "   0"
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    wait_an(4'b1110); chk("t1_idx0", seg, 7'b1000000); chk("t1_dp", 7'(dp), 7'd1);
    wait_an(4'b1101); chk("t1_idx1", seg, 7'h7F);
    wait_an(4'b0111); chk("t1_idx3", seg, 7'h7F);
    chk("t1_ready", 7'(result_ready), 7'd1);

    // 2: +25
    send(6'sd25, 1'b0, 1'b0, 1'b0);
    wait_idle(lows); chk_int("t2_busy_cycles", lows, 7);
    wait_an(4'b1101); chk("t2_idx1", seg, 7'b0100100);
    wait_an(4'b1110); chk("t2_idx0", seg, 7'b0010010);
    wait_an(4'b1011); chk("t2_idx2", seg, 7'h7F);
    wait_an(4'b0111); chk("t2_idx3", seg, 7'h7F);

    // 3: most negative value, -32
    send(6'b100000, 1'b0, 1'b0, 1'b0);
    wait_idle(lows);
    wait_an(4'b0111); chk("t3_idx3", seg, 7'b0111111);
    wait_an(4'b1110); chk("t3_idx0", seg, 7'b0100100);
    wait_an(4'b1101); chk("t3_idx1", seg, 7'b0110000);
    wait_an(4'b1011); chk("t3_idx2", seg, 7'h7F);

    // 4: zero with overflow flag -> decimal point on ones digit
    send(6'd0, 1'b1, 1'b0, 1'b1);
    wait_idle(lows);
    chk("t4_led", 7'(led_flags), 7'b0000101);
    wait_an(4'b1110); chk("t4_idx0", seg, 7'b1000000); chk("t4_dp", 7'(dp), 7'd0);
    wait_an(4'b1101); chk("t4_dp_idx1", 7'(dp), 7'd1);

    // 5: 7 accepted, 9 held valid during conversion, taken on first idle cycle
    send(6'sd7, 1'b0, 1'b0, 1'b0);
    result = 6'sd9; result_valid = 1'b1;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_ready) break;
      lows++;
    end
    chk_int("t5_held_busy", lows, 7);
    @(posedge clk); #1 result_valid = 1'b0;
    @(negedge clk); chk("t5_second_accept", 7'(result_ready), 7'd0);
    wait_idle(lows); chk_int("t5_second_busy", lows, 6);
    wait_an(4'b1110); chk("t5_idx0", seg, 7'b0010000);
    chk("t5_led", 7'(led_flags), 7'd0);

    // 6: reset during the 3rd conversion cycle aborts
    send(6'sd25, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_ready", 7'(result_ready), 7'd1);
    chk("t6_led", 7'(led_flags), 7'd0);
    wait_an(4'b1110); chk("t6_idx0", seg, 7'b1000000); chk("t6_dp", 7'(dp), 7'd1);
    wait_an(4'b1101); chk("t6_idx1", seg, 7'h7F);
    wait_an(4'b0111); chk("t6_idx3", seg, 7'h7F);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
